// File: rtl/bios_uart_rx.sv
// 8N1 UART receiver with 2-FF synchroniser, glitch-rejecting start detect and a small byte FIFO.
// Define BIOS_UART_RX_PARITY_EN to receive 8E1 frames and flag parity mismatches.
module bios_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef BIOS_UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic          sync1_q, rx_s_q;
  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          push, push_ok, pop, full;
  logic          tmr_zero;
`ifdef BIOS_UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          parity_err_q, parity_err_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef BIOS_UART_RX_PARITY_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef BIOS_UART_RX_PARITY_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign tmr_zero = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
`ifdef BIOS_UART_RX_PARITY_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          timer_d = HALF_RELOAD;
        end
      end
      S_START: begin
        if (!tmr_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          timer_d   = FULL_RELOAD;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (!tmr_zero) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          timer_d   = FULL_RELOAD;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) begin
`ifdef BIOS_UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef BIOS_UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tmr_zero) begin
          timer_d = timer_q - 1'b1;
        end else begin
          par_d   = rx_s_q;
          timer_d = FULL_RELOAD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tmr_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (rx_s_q) begin
          state_d = S_IDLE;
`ifdef BIOS_UART_RX_PARITY_EN
          if (^{shift_q, par_q}) parity_err_d = 1'b1;
          else                   push         = 1'b1;
`else
          push = 1'b1;
`endif
        end else begin
          // Low stop bit: hold in BREAK so a stuck-low line is not read as 0x00 frames.
          frame_err_d = 1'b1;
          state_d     = S_BREAK;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full      = (count_q == DEPTH_CNT);
  assign pop       = o_valid & i_ready;
  assign push_ok   = push & (~full | pop);
  assign overrun_d = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_ok) - CW'(pop);
    end
  end

  assign o_data      = mem_q[rd_ptr_q];
  assign o_valid     = (count_q != '0);
  assign o_busy      = (state_q != S_IDLE);
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
`ifdef BIOS_UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bios_uart_rx.sv
// Directed bench for bios_uart_rx at CLKS_PER_BIT=16, FIFO_DEPTH=4.
module tb_bios_uart_rx;

  localparam int CPB = 16;
`ifdef BIOS_UART_RX_PARITY_EN
  localparam int PUSH_OFS = 171;
`else
  localparam int PUSH_OFS = 155;
`endif

  logic       clk, rst, i_rx, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_frame_err, o_overrun, o_parity_err;

  bios_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_busy(o_busy), .o_frame_err(o_frame_err),
    .o_overrun(o_overrun), .o_parity_err(o_parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0, n_vcyc = 0;
  int b_ferr, b_ovr, b_perr, b_vcyc, b_got;
  logic [7:0] got[$];
`ifdef BIOS_UART_RX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_b);
    i_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      wait_clks(CPB);
    end
`ifdef BIOS_UART_RX_PARITY_EN
    i_rx = (^b) ^ flip_par;
    wait_clks(CPB);
`endif
    i_rx = stop_b;
    wait_clks(CPB);
  endtask

  task automatic snap();
    b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr;
    b_vcyc = n_vcyc; b_got = got.size();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid) n_vcyc++;
      if (o_valid && i_ready) got.push_back(o_data);
      if (o_frame_err) n_ferr++;
      if (o_overrun) n_ovr++;
      if (o_parity_err) n_perr++;
      if (o_frame_err || o_overrun || o_parity_err)
        check("err_exclusive", int'(o_frame_err) + int'(o_overrun) + int'(o_parity_err), 1);
    end
  end

  initial begin
    rst = 1'b1; i_rx = 1'b1; i_ready = 1'b0;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(1);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_data, 0);
    check("rst_errs", {o_frame_err, o_overrun, o_parity_err}, 0);

    // Clean 0xA5 with consumer ready
    i_ready = 1'b1;
    snap();
    send(8'hA5, 1'b1);
    wait_clks(4);
    check("a5_count", got.size() - b_got, 1);
    check("a5_data", got[b_got], 8'hA5);
    check("a5_vcyc", n_vcyc - b_vcyc, 1);
    check("a5_errs", (n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr), 0);
    check("a5_busy", o_busy, 0);

    // Start-bit glitch
    snap();
    i_rx = 1'b0;
    wait_clks(5);
    i_rx = 1'b1;
    wait_clks(10);
    check("glitch_busy", o_busy, 0);
    wait_clks(20);
    check("glitch_nobyte", got.size() - b_got, 0);
    check("glitch_errs", (n_ferr - b_ferr) + (n_ovr - b_ovr) + (n_perr - b_perr), 0);

    // Framing error followed by held-low line
    snap();
    send(8'h3C, 1'b0);
    wait_clks(40);
    check("brk_busy_low", o_busy, 1);
    i_rx = 1'b1;
    wait_clks(20);
    check("ferr_count", n_ferr - b_ferr, 1);
    check("ferr_nobyte", got.size() - b_got, 0);
    check("ferr_busy", o_busy, 0);
    snap();
    send(8'h11, 1'b1);
    wait_clks(4);
    check("post_ferr_count", got.size() - b_got, 1);
    check("post_ferr_data", got[b_got], 8'h11);
    check("post_ferr_noerr", n_ferr - b_ferr, 0);

    // Overrun: fifth byte dropped
    i_ready = 1'b0;
    snap();
    for (int b = 1; b <= 5; b++) begin
      send(8'(b), 1'b1);
      wait_clks(2);
    end
    wait_clks(4);
    check("ovr_count", n_ovr - b_ovr, 1);
    check("ovr_valid", o_valid, 1);
    check("ovr_head", o_data, 8'h01);
    i_ready = 1'b1;
    wait_clks(8);
    check("ovr_drain_n", got.size() - b_got, 4);
    for (int i = 0; i < 4; i++) check("ovr_drain_data", got[b_got + i], i + 1);
    check("ovr_empty", o_valid, 0);

    // Full FIFO with a pop on the exact push cycle
    i_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      send(8'(b), 1'b1);
      wait_clks(2);
    end
    wait_clks(4);
    snap();
    fork
      send(8'h05, 1'b1);
      begin
        wait_clks(PUSH_OFS - 1);
        i_ready = 1'b1;
        wait_clks(1);
        i_ready = 1'b0;
      end
    join
    wait_clks(4);
    check("pp_no_ovr", n_ovr - b_ovr, 0);
    check("pp_valid", o_valid, 1);
    i_ready = 1'b1;
    wait_clks(8);
    check("pp_drain_n", got.size() - b_got, 5);
    for (int i = 0; i < 5; i++) check("pp_drain_data", got[b_got + i], i + 1);
    check("pp_empty", o_valid, 0);

    // Reset mid-frame with bytes buffered
    i_ready = 1'b0;
    send(8'h21, 1'b1);
    wait_clks(2);
    send(8'h22, 1'b1);
    wait_clks(4);
    check("pre_rst_valid", o_valid, 1);
    i_rx = 1'b0;
    wait_clks(CPB);
    i_rx = 1'b1;
    wait_clks(4 * CPB + 8);
    check("mid_data_busy", o_busy, 1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_data", o_data, 0);
    check("rst_mid_busy", o_busy, 0);
    wait_clks(20);
    i_ready = 1'b1;
    snap();
    send(8'h5A, 1'b1);
    wait_clks(6);
    check("post_rst_count", got.size() - b_got, 1);
    check("post_rst_data", got[b_got], 8'h5A);

`ifdef BIOS_UART_RX_PARITY_EN
    snap();
    flip_par = 1'b1;
    send(8'h07, 1'b1);
    flip_par = 1'b0;
    wait_clks(4);
    check("perr_count", n_perr - b_perr, 1);
    check("perr_nobyte", got.size() - b_got, 0);
    check("perr_no_ferr", n_ferr - b_ferr, 0);
`else
    check("no_parity_pulses", n_perr, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
